hit_score_tracker: RTL and testbench
====================================

// Module: hit_score_tracker
// PURPOSE
//  Multi-channel hit scorer for the game datapath. Each of N_CH sensor inputs is
//  synchronised and edge-detected, then held off for a lockout window. Accepted
//  hits add to one shared saturating score that drives an LED bar and a win flag.
//  Sits between the raw sensor pins and the display/game-state logic.
// PARAMETERS
//  N_CH         2           number of hit sensor channels (1..8)
//  SCORE_W      3           score register width
//  MAX_SCORE    5           saturation/win value; must be < 2**SCORE_W
//  LOCKOUT_CYC  50_000_000  per-channel dead time in clk cycles (>=1); 1 s at 50 MHz
//  LED_MODE     2           0 = one-hot, 1 = thermometer, 2 = sticky (bits set once reached)
//  (localparam LED_N = MAX_SCORE+1)
// PORTS
//  clk         in   1        system clock
//  resetn      in   1        asynchronous reset, active-low
//  hit_in      in   N_CH     raw asynchronous sensor levels
//  clear       in   1        synchronous game clear
//  ready       out  N_CH     1 = channel armed, 0 = channel in lockout
//  hit_pulse   out  N_CH     one-cycle strobe per accepted hit
//  score       out  SCORE_W  current score
//  win         out  1        sticky; high once score == MAX_SCORE
//  led         out  LED_N    score display
// BEHAVIOUR
//  - Reset (async, resetn=0): score=0, win=0, led=0, hit_pulse=0, ready=all 1, all
//    channels ARMED, timers 0, synchroniser flops 0. Mid-lockout reset re-arms at once.
//  - Per channel: 2-FF sync -> rising edge = sync2 & ~sync2_d. Sample edge E0 captures
//    the high level; edge is seen after E1; at E2 the hit is accepted: hit_pulse=1 for one
//    cycle, ready falls, score updated. Latency hit_in rise -> score = 3 clk edges.
//  - Channel FSM: ARMED --rise--> LOCKED (timer=LOCKOUT_CYC-1); LOCKED decrements;
//    at timer==0 -> ARMED. ready=0 for exactly LOCKOUT_CYC cycles.
//  - Rises during LOCKED are discarded, never queued. A level held high across lockout
//    end does not re-trigger; a fresh 0->1 is required.
//  - Score: next = min(score + popcount(accepts), MAX_SCORE); simultaneous accepts on
//    several channels all count in the same cycle. Hits at saturation still pulse and
//    lock out but leave score unchanged. No wrap-around ever.
//  - win: set in the cycle score reaches MAX_SCORE; cleared only by clear/reset.
//  - clear: score=0, win=0, sticky LEDs=0 next edge; does not touch channel FSMs. A
//    clear in the same cycle as an accept wins: the hit is dropped (hit_pulse still fires).
//  - led registered, lags score by one cycle:
//    mode 0: led[score]=1 only; mode 1: led[i]=1 for i<=score;
//    mode 2: led |= onehot(score), cleared by clear. After reset/clear led[0] sets next cycle.
// STRUCTURE
//  - score_pkg: LED mode enum (LED_ONEHOT, LED_THERM, LED_STICKY), channel state
//    typedef (CH_ARMED, CH_LOCKED), popcount function.
//  - Sub-module hit_channel: sync + edge detect + lockout FSM/timer per channel,
//    generate-instantiated N_CH times; top holds score, win, LED logic.
//  - Timer width $clog2(LOCKOUT_CYC+1); parameter checks via initial assertions.
// TESTING  (N_CH=2, SCORE_W=3, MAX_SCORE=5, LOCKOUT_CYC=8, LED_MODE=2 unless noted)
//  1 Reset, pulse hit_in[0] -> score 0->1 on 3rd edge, hit_pulse[0] one cycle, ready[0]=0 8 cycles.
//  2 Second hit_in[0] rise 4 cycles into lockout; then hold high past lockout end -> score stays 1.
//  3 hit_in[0] and hit_in[1] rise same edge -> score +2 in one cycle, both ready low 8 cycles.
//  4 From score 4, both channels hit -> score 5 (not 6), win=1; later hits -> score 5, pulses fire.
//  5 Scores 0..3 in mode 2 -> led=6'b001111; clear -> led=0 then 6'b000001; mode 1 at 3 -> 6'b001111;
//    mode 0 at 3 -> 6'b001000.
//  6 clear coincident with accept -> score 0; resetn low mid-lockout -> ready=all 1, score 0 async.

Source files
------------

// File: rtl/hit_score_tracker_pkg.sv
// Shared types for the hit scorer: LED display modes, channel lockout states
// and a small popcount used to merge simultaneous accepts.
package score_pkg;

    typedef enum logic [1:0] {
        LED_ONEHOT = 2'd0,
        LED_THERM  = 2'd1,
        LED_STICKY = 2'd2
    } led_mode_e;

    typedef enum logic {
        CH_ARMED  = 1'b0,
        CH_LOCKED = 1'b1
    } ch_state_e;

    localparam int MAX_CH = 8;

    function automatic logic [3:0] popcount8(input logic [MAX_CH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hit_score_tracker_channel.sv
// One sensor channel: 2-FF synchroniser, rising-edge detect and lockout timer.
// accept_o is the combinational "hit taken this cycle" used by the score logic.
module hit_channel
    import score_pkg::*;
#(
    parameter int LOCKOUT_CYC = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hit_i,
    output logic ready_o,
    output logic hit_pulse_o,
    output logic accept_o
);

    localparam int TW = $clog2(LOCKOUT_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          sync2d_q;
    ch_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic          ready_q;
    logic          pulse_q;
    logic          rise;

    // Edges arriving while locked are simply never looked at, so nothing queues.
    always_comb begin
        rise     = sync2_q & ~sync2d_q;
        accept_o = (state_q == CH_ARMED) & rise;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync2d_q <= 1'b0;
            state_q  <= CH_ARMED;
            timer_q  <= '0;
            ready_q  <= 1'b1;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= hit_i;
            sync2_q  <= sync1_q;
            sync2d_q <= sync2_q;
            pulse_q  <= 1'b0;
            case (state_q)
                CH_ARMED: begin
                    if (rise) begin
                        state_q <= CH_LOCKED;
                        timer_q <= TW'(LOCKOUT_CYC - 1);
                        ready_q <= 1'b0;
                        pulse_q <= 1'b1;
                    end
                end
                CH_LOCKED: begin
                    if (timer_q == '0) begin
                        state_q <= CH_ARMED;
                        ready_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= CH_ARMED;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign hit_pulse_o = pulse_q;

endmodule

// File: rtl/hit_score_tracker.sv
// Multi-channel hit scorer: per-channel lockout front ends feeding one shared
// saturating score, a sticky win flag and a registered LED bar.
module hit_score_tracker
    import score_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int SCORE_W     = 3,
    parameter int MAX_SCORE   = 5,
    parameter int LOCKOUT_CYC = 50_000_000,
    parameter int LED_MODE    = 2,
    localparam int LED_N      = MAX_SCORE + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_CH-1:0]    hit_in,
    input  logic               clear,
    output logic [N_CH-1:0]    ready,
    output logic [N_CH-1:0]    hit_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               win,
    output logic [LED_N-1:0]   led
);

    localparam led_mode_e MODE = led_mode_e'(LED_MODE);
    localparam int        SUM_W = SCORE_W + 4;

    if (N_CH < 1 || N_CH > MAX_CH) begin : g_chk_nch
        $error("hit_score_tracker: N_CH must be 1..8");
    end
    if (MAX_SCORE >= (2 ** SCORE_W) || MAX_SCORE < 1) begin : g_chk_max
        $error("hit_score_tracker: MAX_SCORE must be 1..2**SCORE_W-1");
    end
    if (LOCKOUT_CYC < 1) begin : g_chk_lock
        $error("hit_score_tracker: LOCKOUT_CYC must be >= 1");
    end
    if (LED_MODE < 0 || LED_MODE > 2) begin : g_chk_mode
        $error("hit_score_tracker: LED_MODE must be 0, 1 or 2");
    end

    logic [N_CH-1:0] accept;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        hit_channel #(
            .LOCKOUT_CYC(LOCKOUT_CYC)
        ) u_ch (
            .clk_i      (clk),
            .rst_ni     (resetn),
            .hit_i      (hit_in[g]),
            .ready_o    (ready[g]),
            .hit_pulse_o(hit_pulse[g]),
            .accept_o   (accept[g])
        );
    end

    logic [SCORE_W-1:0] score_q, score_d;
    logic               win_q, win_d;
    logic [LED_N-1:0]   led_q, led_d;
    logic [MAX_CH-1:0]  acc8;
    logic [SUM_W-1:0]   sum;
    logic [LED_N-1:0]   onehot;
    logic [LED_N-1:0]   therm;

    // Sum is formed wide enough for MAX_SCORE + 8 so saturation never sees a wrap.
    always_comb begin
        acc8             = '0;
        acc8[N_CH-1:0]   = accept;
        sum              = SUM_W'(score_q) + SUM_W'(popcount8(acc8));
        if (clear) begin
            score_d = '0;
        end else if (sum >= SUM_W'(MAX_SCORE)) begin
            score_d = SCORE_W'(MAX_SCORE);
        end else begin
            score_d = sum[SCORE_W-1:0];
        end
        win_d = clear ? 1'b0 : (win_q | (score_d == SCORE_W'(MAX_SCORE)));
    end

    // LED bar is derived from the registered score, so it trails it by one cycle.
    always_comb begin
        onehot = '0;
        therm  = '0;
        for (int i = 0; i < LED_N; i++) begin
            onehot[i] = (score_q == SCORE_W'(i));
            therm[i]  = (score_q >= SCORE_W'(i));
        end
        case (MODE)
            LED_ONEHOT: led_d = onehot;
            LED_THERM:  led_d = therm;
            default:    led_d = clear ? '0 : (led_q | onehot);
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q <= '0;
            win_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            score_q <= score_d;
            win_q   <= win_d;
            led_q   <= led_d;
        end
    end

    assign score = score_q;
    assign win   = win_q;
    assign led   = led_q;

endmodule

// File: tb/tb_hit_score_tracker.sv
// Directed bench for hit_score_tracker: three instances share stimulus and
// differ only in LED_MODE (2 = main, 1 and 0 for the display comparisons).
module tb_hit_score_tracker;

    localparam int N_CH  = 2;
    localparam int SW    = 3;
    localparam int MAXS  = 5;
    localparam int LOCK  = 8;
    localparam int LED_N = MAXS + 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic [N_CH-1:0]  hit_in;
    logic             clear;

    logic [N_CH-1:0]  ready, ready_m1, ready_m0;
    logic [N_CH-1:0]  hit_pulse, hit_pulse_m1, hit_pulse_m0;
    logic [SW-1:0]    score, score_m1, score_m0;
    logic             win, win_m1, win_m0;
    logic [LED_N-1:0] led, led_m1, led_m0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    hit_score_tracker #(.N_CH(N_CH), .SCORE_W(SW), .MAX_SCORE(MAXS), .LOCKOUT_CYC(LOCK), .LED_MODE(2)) u_dut (
        .clk(clk), .resetn(resetn), .hit_in(hit_in), .clear(clear),
        .ready(ready), .hit_pulse(hit_pulse), .score(score), .win(win), .led(led));

    hit_score_tracker #(.N_CH(N_CH), .SCORE_W(SW), .MAX_SCORE(MAXS), .LOCKOUT_CYC(LOCK), .LED_MODE(1)) u_m1 (
        .clk(clk), .resetn(resetn), .hit_in(hit_in), .clear(clear),
        .ready(ready_m1), .hit_pulse(hit_pulse_m1), .score(score_m1), .win(win_m1), .led(led_m1));

    hit_score_tracker #(.N_CH(N_CH), .SCORE_W(SW), .MAX_SCORE(MAXS), .LOCKOUT_CYC(LOCK), .LED_MODE(0)) u_m0 (
        .clk(clk), .resetn(resetn), .hit_in(hit_in), .clear(clear),
        .ready(ready_m0), .hit_pulse(hit_pulse_m0), .score(score_m0), .win(win_m0), .led(led_m0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raise the given sensors and return right after the accepting edge (E2).
    task automatic hit(input logic [N_CH-1:0] mask);
        hit_in = mask;
        ticks(3);
        hit_in = '0;
    endtask

    initial begin
        int cnt;
        int pulses;

        resetn = 1'b0;
        hit_in = '0;
        clear  = 1'b0;
        ticks(3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_win",   32'(win),   32'd0);
        chk("rst_led",   32'(led),   32'd0);
        chk("rst_ready", 32'(ready), 32'b11);
        chk("rst_pulse", 32'(hit_pulse), 32'd0);
        resetn = 1'b1;
        tick();
        chk("led0_after_rst", 32'(led), 32'b000001);

        // Single hit: latency, one-cycle pulse, lockout length; re-hit inside lockout.
        hit_in = 2'b01;
        tick();
        chk("lat_e0_score", 32'(score), 32'd0);
        tick();
        chk("lat_e1_score", 32'(score), 32'd0);
        chk("lat_e1_pulse", 32'(hit_pulse), 32'd0);
        tick();
        chk("lat_e2_score", 32'(score), 32'd1);
        chk("lat_e2_pulse", 32'(hit_pulse), 32'b01);
        chk("lat_e2_ready", 32'(ready), 32'b10);
        hit_in = 2'b00;
        cnt    = 1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) hit_in = 2'b01;
            tick();
            if (!ready[0]) cnt++;
            if (hit_pulse[0]) pulses++;
        end
        chk("lock_len_ch0",    32'(cnt), 32'd8);
        chk("lock_no_retrig",  32'(pulses), 32'd0);
        chk("lock_score_held", 32'(score), 32'd1);
        hit_in = 2'b00;
        ticks(4);

        // Both channels on the same edge.
        hit(2'b11);
        chk("dual_score", 32'(score), 32'd3);
        chk("dual_pulse", 32'(hit_pulse), 32'b11);
        chk("dual_ready", 32'(ready), 32'b00);
        cnt = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ready == 2'b00) cnt++;
            if (i == 0) begin
                chk("dual_led_m2", 32'(led),    32'b001011);
                chk("dual_led_m1", 32'(led_m1), 32'b001111);
                chk("dual_led_m0", 32'(led_m0), 32'b001000);
            end
        end
        chk("dual_lock_len", 32'(cnt), 32'd8);

        // Saturation and win.
        hit(2'b10);
        chk("sat_score4", 32'(score), 32'd4);
        chk("sat_win0",   32'(win),   32'd0);
        ticks(10);
        hit(2'b11);
        chk("sat_score5", 32'(score), 32'd5);
        chk("sat_win1",   32'(win),   32'd1);
        tick();
        chk("sat_led_m2", 32'(led), 32'b111011);
        ticks(9);
        hit(2'b01);
        chk("sat_hold",  32'(score), 32'd5);
        chk("sat_pulse", 32'(hit_pulse), 32'b01);
        chk("sat_ready", 32'(ready), 32'b10);
        chk("sat_win_sticky", 32'(win), 32'd1);
        ticks(10);

        // Clear, then clear coincident with an accept.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_score", 32'(score), 32'd0);
        chk("clr_win",   32'(win),   32'd0);
        chk("clr_led",   32'(led),   32'd0);
        tick();
        chk("clr_led0",  32'(led),   32'b000001);
        hit_in = 2'b01;
        ticks(2);
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        hit_in = 2'b00;
        chk("clrhit_score", 32'(score), 32'd0);
        chk("clrhit_pulse", 32'(hit_pulse), 32'b01);
        tick();
        chk("clrhit_score_next", 32'(score), 32'd0);
        ticks(10);

        // Asynchronous reset in the middle of a lockout.
        hit(2'b10);
        chk("pre_rst_score", 32'(score), 32'd1);
        ticks(2);
        chk("pre_rst_ready", 32'(ready), 32'b01);
        resetn = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'b11);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_led",   32'(led),   32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Score 0..3 one step at a time for the display modes.
        for (int k = 1; k <= 3; k++) begin
            hit(2'b01);
            chk("step_score", 32'(score), 32'(k));
            ticks(10);
        end
        chk("step_led_m2", 32'(led),    32'b001111);
        chk("step_led_m1", 32'(led_m1), 32'b001111);
        chk("step_led_m0", 32'(led_m0), 32'b001000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
